// File: rtl/alu_pkg.sv
// Shared constants, types and CRC-4 helpers for the ALU serial packet receiver.
package alu_pkg;

  localparam logic [3:0]  CRC4_POLY  = 4'h3;
  localparam int unsigned FRAME_BITS = 11;
  localparam logic        CMD_CTL    = 1'b1;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  typedef struct packed {
    logic data;
    logic crc;
    logic op;
  } err_t;

  function automatic logic [3:0] crc4_bit(input logic [3:0] crc, input logic b);
    return {crc[2:0], 1'b0} ^ ((crc[3] ^ b) ? CRC4_POLY : 4'h0);
  endfunction

  function automatic logic [3:0] crc4_byte(input logic [3:0] crc, input logic [7:0] b);
    logic [3:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) c = crc4_bit(c, b[7-i]);
    return c;
  endfunction

  // Command trailer: a marker 1 followed by the opcode, MSB first.
  function automatic logic [3:0] crc4_tail(input logic [3:0] crc, input logic [2:0] op);
    logic [3:0] c;
    c = crc4_bit(crc, 1'b1);
    for (int unsigned i = 0; i < 3; i++) c = crc4_bit(c, op[2-i]);
    return c;
  endfunction

endpackage

// File: rtl/alu_uart_byte_rx.sv
// Frame deserialiser: start 0, ctl, d[7:0] MSB first, stop 1. Strobes during the stop cycle.
module alu_uart_byte_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ctl,
  output logic       frame_err
);

  localparam logic [3:0] LAST = 4'(FRAME_BITS - 2);

  rx_state_t  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg;
  logic       ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      ctl   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == SHIFT) begin
        if (cnt == 4'd0)
          ctl <= sin;
        else if (cnt != LAST)
          shreg <= {shreg[6:0], sin};
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (!sin) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The stop bit is judged combinationally so the byte is usable on the edge that samples it.
  assign byte_valid = (state == SHIFT) && (cnt == LAST);
  assign frame_err  = byte_valid && !sin;
  assign byte_data  = shreg;
  assign byte_ctl   = ctl;

endmodule

// File: rtl/alu_frame_rx.sv
// ALU packet receiver: assembles operands, checks length/CRC-4/opcode, presents one result per packet.
module alu_frame_rx
  import alu_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_OPS   = 2,
  parameter logic [7:0]  LEGAL_OPS = 8'b0011_0011
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [NUM_OPS*DATA_W-1:0]   out_data,
  output logic [2:0]                  out_op,
  output logic                        err_data,
  output logic                        err_crc,
  output logic                        err_op,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned PW     = NUM_OPS * DATA_W;
  localparam int unsigned NBYTES = PW / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 2);
  localparam logic [CW-1:0] NB_FULL = CW'(NBYTES);
  localparam logic [CW-1:0] NB_SAT  = CW'(NBYTES + 1);

  logic          byte_valid, byte_ctl, frame_err;
  logic [7:0]    byte_data;
  logic [CW-1:0] cnt;
  logic [3:0]    crc;
  logic [PW-1:0] shreg;
  logic          framing;
  logic          data_ok, cmd, dbyte;
  logic [2:0]    op;
  err_t          err;

  alu_uart_byte_rx u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ctl   (byte_ctl),
    .frame_err  (frame_err)
  );

  always_comb begin
    data_ok = byte_valid && !frame_err;
    cmd     = data_ok && (byte_ctl == CMD_CTL);
    dbyte   = data_ok && (byte_ctl != CMD_CTL);
    op      = byte_data[6:4];
    err     = '0;
    if ((cnt != NB_FULL) || framing)
      err.data = 1'b1;
    else if (crc4_tail(crc, op) != byte_data[3:0])
      err.crc = 1'b1;
    else if (!LEGAL_OPS[op])
      err.op = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      crc       <= '0;
      shreg     <= '0;
      framing   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_op    <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (frame_err)
        framing <= 1'b1;

      if (dbyte) begin
        if (cnt < NB_FULL)
          shreg <= (shreg << 8) | PW'(byte_data);
        if (cnt != NB_SAT)
          cnt <= cnt + 1'b1;
        crc <= crc4_byte(crc, byte_data);
      end

      if (cmd) begin
        cnt     <= '0;
        crc     <= '0;
        shreg   <= '0;
        framing <= 1'b0;
        // A completing packet may replace the output in the very cycle it is consumed.
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= err.data ? '0 : shreg;
          out_op    <= op;
          err_data  <= err.data;
          err_crc   <= err.crc;
          err_op    <= err.op;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
